// File: rtl/arcade_input_conditioner.sv
// Arcade input conditioner: sync + debounce, queued frame-timed coin pulses.
// Autofire on masked buttons is built only when AUTOFIRE_EN is defined.
module arcade_input_conditioner #(
    parameter int              NBTN        = 16,
    parameter int              DEB_CYCLES  = 48000,
    parameter int              COIN_FRAMES = 3,
    parameter int              COIN_GAP    = 3,
    parameter logic [NBTN-1:0] AF_MASK     = '0,
    parameter int              AF_FRAMES   = 4
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic [NBTN-1:0] btn_raw,
    input  logic [1:0]      coin_raw,
    input  logic            vblank,
    output logic [NBTN-1:0] btn_out,
    output logic [1:0]      coin_out,
    output logic [7:0]      coin_count,
    output logic [1:0]      q_full
);

    localparam int NIN  = NBTN + 2;
    localparam int DW   = $clog2(DEB_CYCLES);
    localparam int FMAX = (COIN_FRAMES > COIN_GAP) ? COIN_FRAMES : COIN_GAP;
    localparam int FW   = (FMAX > 1) ? $clog2(FMAX) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [FW-1:0] PULSE_LAST = FW'(COIN_FRAMES - 1);
    localparam logic [FW-1:0] GAP_LAST = FW'(COIN_GAP - 1);

    if (DEB_CYCLES < 2 || COIN_FRAMES < 1 || COIN_GAP < 1 ||
        AF_FRAMES < 1 || $bits(AF_MASK) != NBTN) begin : g_bad_cfg
        $error("arcade_input_conditioner: invalid parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    logic [NIN-1:0] meta;
    logic [NIN-1:0] sync;
    logic [NIN-1:0] deb;
    logic [DW-1:0]  dcnt [NIN];
    logic [1:0]     coin_d;
    logic [2:0]     vs_pipe;
    logic           tick;

    coin_state_t    state   [2];
    logic [FW-1:0]  fcnt    [2];
    logic [1:0]     pending [2];
    logic [1:0]     rise;
    logic [1:0]     start;

    // vs_pipe: [0] meta, [1] synced level, [2] one-cycle delay
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            meta    <= '0;
            sync    <= '0;
            vs_pipe <= '0;
        end else begin
            meta    <= {coin_raw, btn_raw};
            sync    <= meta;
            vs_pipe <= {vs_pipe[1:0], vblank};
        end
    end

    assign tick = vs_pipe[1] & ~vs_pipe[2];

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            deb    <= '0;
            coin_d <= '0;
            for (int i = 0; i < NIN; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            coin_d <= deb[NBTN +: 2];
            for (int i = 0; i < NIN; i++) begin
                if (sync[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_MAX) begin
                    deb[i]  <= sync[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = deb[NBTN +: 2] & ~coin_d;

    always_comb begin
        start = '0;
        for (int c = 0; c < 2; c++) begin
            start[c] = (state[c] == IDLE) && (pending[c] != 2'd0);
        end
    end

    // An edge arriving on a dequeue cycle replaces the coin being issued.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            coin_out   <= '0;
            coin_count <= '0;
            for (int c = 0; c < 2; c++) begin
                state[c]   <= IDLE;
                fcnt[c]    <= '0;
                pending[c] <= '0;
            end
        end else begin
            coin_count <= coin_count + 8'(start[0]) + 8'(start[1]);
            for (int c = 0; c < 2; c++) begin
                if (rise[c] && !start[c] && pending[c] != 2'd3) begin
                    pending[c] <= pending[c] + 2'd1;
                end else if (start[c] && !rise[c]) begin
                    pending[c] <= pending[c] - 2'd1;
                end
                unique case (state[c])
                    IDLE: begin
                        if (start[c]) begin
                            fcnt[c]     <= '0;
                            coin_out[c] <= 1'b1;
                            state[c]    <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (tick) begin
                            if (fcnt[c] == PULSE_LAST) begin
                                coin_out[c] <= 1'b0;
                                fcnt[c]     <= '0;
                                state[c]    <= GAP;
                            end else begin
                                fcnt[c] <= fcnt[c] + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (fcnt[c] == GAP_LAST) begin
                                state[c] <= IDLE;
                            end else begin
                                fcnt[c] <= fcnt[c] + 1'b1;
                            end
                        end
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

    assign q_full = {pending[1] == 2'd3, pending[0] == 2'd3};

`ifdef AUTOFIRE_EN
    localparam int AW = (AF_FRAMES > 1) ? $clog2(AF_FRAMES) : 1;
    localparam logic [AW-1:0] AF_LAST = AW'(AF_FRAMES - 1);

    logic [NBTN-1:0] btn_d;
    logic [AW-1:0]   af_cnt;
    logic            phase;
    logic            af_rise;

    assign af_rise = |(AF_MASK & deb[NBTN-1:0] & ~btn_d);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            btn_d  <= '0;
            af_cnt <= '0;
            phase  <= 1'b0;
        end else begin
            btn_d <= deb[NBTN-1:0];
            if (af_rise) begin
                phase  <= 1'b1;
                af_cnt <= '0;
            end else if (tick) begin
                if (af_cnt == AF_LAST) begin
                    phase  <= ~phase;
                    af_cnt <= '0;
                end else begin
                    af_cnt <= af_cnt + 1'b1;
                end
            end
        end
    end

    // af_rise bypasses the phase flop so the first shot is not delayed.
    assign btn_out = (deb[NBTN-1:0] & ~AF_MASK) |
                     (deb[NBTN-1:0] & AF_MASK & {NBTN{phase | af_rise}});
`else
    assign btn_out = deb[NBTN-1:0];
`endif

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Bench for arcade_input_conditioner: debounce vector table, directed coin
// sequences and a randomized run checked against an input-history model.
`timescale 1ns/1ps
module tb_arcade_input_conditioner;

    localparam int NBTN = 16;
    localparam int DEB  = 8;
    localparam int CF   = 2;
    localparam int CG   = 2;
    localparam int HN   = 16384;

    logic            clk_sys = 1'b0;
    logic            RESET;
    logic [NBTN-1:0] btn_raw;
    logic [1:0]      coin_raw;
    logic            vblank;
    logic [NBTN-1:0] btn_out;
    logic [1:0]      coin_out;
    logic [7:0]      coin_count;
    logic [1:0]      q_full;

    arcade_input_conditioner #(
        .NBTN(NBTN), .DEB_CYCLES(DEB), .COIN_FRAMES(CF), .COIN_GAP(CG),
        .AF_MASK(16'h0001), .AF_FRAMES(1)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .btn_raw(btn_raw),
        .coin_raw(coin_raw), .vblank(vblank), .btn_out(btn_out),
        .coin_out(coin_out), .coin_count(coin_count), .q_full(q_full)
    );

    always #5 clk_sys = ~clk_sys;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int base       = 0;

    // Input history per cycle: {RESET, vblank, coin_raw, btn_raw}
    logic [19:0] hist [HN];

    logic [17:0] m_deb;
    logic [17:0] m_deb_p;
    logic [1:0]  m_out;
    int          m_pend [2];
    int          m_hi   [2];
    int          m_gap  [2];
    int          m_count;

    typedef struct {
        int   idx;
        int   width;
        logic exp_hit;
    } deb_vec_t;

    deb_vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Synchronised level of input bit b during cycle u.
    function automatic logic s_of(input int b, input int u);
        if (u - 2 < 0 || u - 2 < base) return 1'b0;
        return hist[(u - 2) % HN][b];
    endfunction

    task automatic model_step();
        int          t;
        logic [17:0] dn;
        logic        tk;
        logic [1:0]  rs;
        bit          all;
        bit          deq;
        t = cyc;
        if (hist[(t - 1) % HN][19]) begin
            base    = t;
            m_deb   = '0;
            m_deb_p = '0;
            m_out   = '0;
            m_count = 0;
            for (int c = 0; c < 2; c++) begin
                m_pend[c] = 0;
                m_hi[c]   = 0;
                m_gap[c]  = 0;
            end
            return;
        end
        // A level is accepted once it has differed for DEB straight cycles.
        dn = m_deb;
        for (int b = 0; b < 18; b++) begin
            all = 1'b1;
            for (int u = t - DEB; u < t; u++) begin
                if (s_of(b, u) == m_deb[b]) all = 1'b0;
            end
            if (all) dn[b] = ~m_deb[b];
        end
        tk = s_of(18, t - 1) & ~s_of(18, t - 2);
        rs = m_deb[17:16] & ~m_deb_p[17:16];
        for (int c = 0; c < 2; c++) begin
            deq = (m_hi[c] == 0) && (m_gap[c] == 0) && (m_pend[c] > 0);
            if (deq) begin
                m_out[c] = 1'b1;
                m_hi[c]  = CF;
                m_count  = (m_count + 1) % 256;
            end else if (m_hi[c] > 0) begin
                if (tk) begin
                    m_hi[c]--;
                    if (m_hi[c] == 0) begin
                        m_out[c] = 1'b0;
                        m_gap[c] = CG;
                    end
                end
            end else if (m_gap[c] > 0) begin
                if (tk) m_gap[c]--;
            end
            m_pend[c] = m_pend[c] + int'(rs[c]) - (deq ? 1 : 0);
            if (m_pend[c] > 3) m_pend[c] = 3;
        end
        m_deb_p = m_deb;
        m_deb   = dn;
    endtask

    task automatic compare_model();
        logic [NBTN-1:0] bm;
        bm = '1;
`ifdef AUTOFIRE_EN
        bm[0] = 1'b0;
`endif
        check("model_btn", btn_out & bm, m_deb[15:0] & bm);
        check("model_coin", coin_out, m_out);
        check("model_count", coin_count, m_count[7:0]);
        check("model_qfull", q_full, {m_pend[1] == 3, m_pend[0] == 3});
    endtask

    task automatic step();
        hist[cyc % HN] = {RESET, vblank, coin_raw, btn_raw};
        @(posedge clk_sys);
        #1;
        cyc++;
        model_step();
        compare_model();
        vblank = ((cyc % 100) >= 50);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align();
        while (cyc % 100 != 0) step();
    endtask

    task automatic fresh_start();
        btn_raw  = '0;
        coin_raw = '0;
        align();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        step();
        align();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0;
        int         rise_at;
        int         fall_at;
        int         pulses;
        logic       prev;
        logic       hit;
        logic       qf_seen;
        logic [1:0] first_val;

        RESET    = 1'b1;
        btn_raw  = '0;
        coin_raw = '0;
        vblank   = 1'b0;
        step();
        step();
        check("rst_btn", btn_out, 0);
        check("rst_coin", coin_out, 0);
        check("rst_count", coin_count, 0);
        check("rst_qfull", q_full, 0);
        RESET = 1'b0;
        align();

        // 5-cycle glitch on button 0 is filtered.
        btn_raw[0] = 1'b1;
        run(5);
        btn_raw[0] = 1'b0;
        hit = 1'b0;
        for (int j = 0; j < 20; j++) begin
            step();
            hit |= btn_out[0];
        end
        check("glitch5", hit, 0);

        // Held step shows up exactly DEB+2 cycles after the raw edge.
        btn_raw[0] = 1'b1;
        run(DEB + 1);
        check("step_lat9", btn_out[0], 0);
        step();
        check("step_lat10", btn_out[0], 1);
        btn_raw[0] = 1'b0;
        run(15);
        check("step_release", btn_out[0], 0);

        tbl[0] = '{1, 3, 1'b0};
        tbl[1] = '{2, 7, 1'b0};
        tbl[2] = '{3, 8, 1'b1};
        tbl[3] = '{4, 9, 1'b1};
        tbl[4] = '{5, 20, 1'b1};
        tbl[5] = '{15, 1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            hit = 1'b0;
            btn_raw[tbl[k].idx] = 1'b1;
            for (int j = 0; j < tbl[k].width + 20; j++) begin
                if (j == tbl[k].width) btn_raw[tbl[k].idx] = 1'b0;
                step();
                hit |= btn_out[tbl[k].idx];
            end
            check($sformatf("deb_b%0d_w%0d", tbl[k].idx, tbl[k].width),
                  hit, tbl[k].exp_hit);
        end

        // Single coin: out at +12, high through the 2nd tick (+152).
        fresh_start();
        c0 = cyc;
        rise_at = -1;
        fall_at = -1;
        pulses  = 0;
        prev    = 1'b0;
        coin_raw[0] = 1'b1;
        for (int j = 0; j < 400; j++) begin
            if (j == 50) coin_raw[0] = 1'b0;
            step();
            if (coin_out[0] && !prev) begin
                pulses++;
                if (rise_at < 0) rise_at = cyc;
            end
            if (!coin_out[0] && prev && fall_at < 0) fall_at = cyc;
            prev = coin_out[0];
        end
        check("coin1_rise", rise_at - c0, DEB + 4);
        check("coin1_fall", fall_at - c0, 153);
        check("coin1_pulses", pulses, 1);
        check("coin1_count", coin_count, 1);

        // Four presses 20 cycles apart: queue fills, four separate pulses.
        fresh_start();
        pulses  = 0;
        prev    = 1'b0;
        qf_seen = 1'b0;
        for (int j = 0; j < 1600; j++) begin
            coin_raw[0] = (j < 80) && ((j % 20) < 10);
            step();
            qf_seen |= q_full[0];
            if (coin_out[0] && !prev) pulses++;
            prev = coin_out[0];
        end
        check("burst_qfull", qf_seen, 1);
        check("burst_pulses", pulses, 4);
        check("burst_count", coin_count, 4);

        // Both coins on the same cycle start together.
        fresh_start();
        c0 = cyc;
        rise_at   = -1;
        first_val = 2'b00;
        coin_raw  = 2'b11;
        for (int j = 0; j < 200; j++) begin
            if (j == 50) coin_raw = 2'b00;
            step();
            if (coin_out != 2'b00 && rise_at < 0) begin
                rise_at   = cyc;
                first_val = coin_out;
                check("dual_count_at_start", coin_count, 2);
            end
        end
        check("dual_first", first_val, 2'b11);
        check("dual_rise", rise_at - c0, DEB + 4);
        check("dual_count", coin_count, 2);

        // Reset mid-pulse with a full queue discards everything.
        fresh_start();
        for (int j = 0; j < 80; j++) begin
            coin_raw[0] = (j < 80) && ((j % 20) < 10);
            step();
        end
        check("pre_rst_pulse", coin_out[0], 1);
        check("pre_rst_qfull", q_full[0], 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_coin", coin_out, 0);
        check("mid_rst_qfull", q_full, 0);
        check("mid_rst_count", coin_count, 0);
        hit = 1'b0;
        for (int j = 0; j < 500; j++) begin
            step();
            hit |= |coin_out;
        end
        check("post_rst_quiet", hit, 0);
        check("post_rst_count", coin_count, 0);

        // Random button and coin activity against the model.
        fresh_start();
        for (int j = 0; j < 3000; j++) begin
            for (int b = 0; b < NBTN; b++) begin
                if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
            end
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 24) == 0) coin_raw[c] = ~coin_raw[c];
            end
            step();
        end

`ifdef AUTOFIRE_EN
        fresh_start();
        btn_raw[0] = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            step();
            if (j == 10) check("af_first", btn_out[0], 1);
            if (j == 52) check("af_pre_tick", btn_out[0], 1);
            if (j == 53) check("af_toggle0", btn_out[0], 0);
            if (j == 152) check("af_pre_tick2", btn_out[0], 0);
            if (j == 153) check("af_toggle1", btn_out[0], 1);
            if (j == 169) check("af_held", btn_out[0], 1);
            if (j == 170) check("af_release", btn_out[0], 0);
            if (j == 160) btn_raw[0] = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
